alarm_clock_alarm: RTL and testbench



---
 rtl/alarm_clock_alarm_pkg.sv | 25 ++
 rtl/alarm_clock_alarm_bcd_time_valid.sv | 19 +
 rtl/alarm_clock_alarm.sv | 107 ++++++++++
 tb/tb_alarm_clock_alarm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_alarm_pkg.sv
// Shared types and BCD limits for the alarm comparator.
// Used by alarm_clock_alarm and bcd_time_valid.
package alarm_clock_alarm_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MIN1_MAX        = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX       = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] HOUR1_MAX       = DIGIT_W'(2);
  localparam logic [DIGIT_W-1:0] HOUR0_MAX_AT_20 = DIGIT_W'(3);

  typedef struct packed {
    logic [DIGIT_W-1:0] hour1;
    logic [DIGIT_W-1:0] hour0;
    logic [DIGIT_W-1:0] min1;
    logic [DIGIT_W-1:0] min0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RING  = 2'd1,
    S_QUIET = 2'd2
  } ring_state_e;

endpackage

// File: rtl/alarm_clock_alarm_bcd_time_valid.sv
// Combinational legality check of a BCD HH:MM value (00:00 .. 23:59).
// Instantiated by alarm_clock_alarm only when ALARM_TIME_CHECK_EN is defined.
module bcd_time_valid
  import alarm_clock_alarm_pkg::*;
(
  input  bcd_time_t i_time,
  output logic      o_valid
);

  logic w_digits_ok;
  logic w_hour_ok;

  assign w_digits_ok = (i_time.min0  <= DIGIT_MAX) && (i_time.min1  <= MIN1_MAX) &&
                       (i_time.hour0 <= DIGIT_MAX) && (i_time.hour1 <= HOUR1_MAX);
  // Twenty-something hours stop at 23.
  assign w_hour_ok   = !((i_time.hour1 == HOUR1_MAX) && (i_time.hour0 > HOUR0_MAX_AT_20));
  assign o_valid     = w_digits_ok && w_hour_ok;

endmodule

// File: rtl/alarm_clock_alarm.sv
// Alarm comparator: captures HH:MM while set is high, rings once per match event.
// Define ALARM_TIME_CHECK_EN to reject out-of-range set samples.
module alarm_clock_alarm #(
  parameter int RING_CYCLES = 0,
  parameter int DIGIT_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic [DIGIT_W-1:0] curMin0,
  input  logic [DIGIT_W-1:0] curMin1,
  input  logic [DIGIT_W-1:0] curHour0,
  input  logic [DIGIT_W-1:0] curHour1,
  output logic               alarm
);
  import alarm_clock_alarm_pkg::*;

  // state   | meaning
  // S_IDLE  | no match on the previous cycle
  // S_RING  | match held, alarm high
  // S_QUIET | match still held, ring time used up, waiting for match to drop
  localparam int CNT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES + 1) : 1;

  ring_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_alarm, w_alarm_nxt;
  logic             r_armed;
  bcd_time_t        r_time;
  bcd_time_t        w_cur;
  logic             w_match;
  logic             w_accept;

  assign w_cur   = {curHour1, curHour0, curMin1, curMin0};
  assign w_match = r_armed && !set && (w_cur == r_time);

`ifdef ALARM_TIME_CHECK_EN
  bcd_time_valid u_valid (
    .i_time  (w_cur),
    .o_valid (w_accept)
  );
`else
  assign w_accept = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_alarm_nxt = 1'b0;
    if (set) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_match) begin
            w_state_nxt = S_RING;
            w_cnt_nxt   = CNT_W'(1);
            w_alarm_nxt = 1'b1;
          end
        end
        S_RING: begin
          if (!w_match) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if ((RING_CYCLES > 0) && (r_cnt >= CNT_W'(RING_CYCLES))) begin
            w_state_nxt = S_QUIET;
          end else begin
            w_alarm_nxt = 1'b1;
            // Saturate so an endless ring never wraps the counter.
            if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_QUIET: begin
          if (!w_match) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_alarm <= 1'b0;
      r_armed <= 1'b0;
      r_time  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_alarm <= w_alarm_nxt;
      if (set && w_accept) begin
        r_time  <= w_cur;
        r_armed <= 1'b1;
      end
    end
  end

  assign alarm = r_alarm;

endmodule

// File: tb/tb_alarm_clock_alarm.sv
// Bench for alarm_clock_alarm: two instances (endless ring and 3-cycle ring)
// checked every cycle against a run-length reference model.
module tb_alarm_clock_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic       set;
  logic [3:0] cm0, cm1, ch0, ch1;
  logic       alarm0, alarm3;

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  // reference model state
  logic [3:0] m_h1, m_h0, m_m1, m_m0;
  logic       m_armed;
  int         m_run;
  logic       e0, e3;

  always #5 clk = ~clk;

  alarm_clock_alarm #(.RING_CYCLES(0), .DIGIT_W(4)) dut0 (
    .clk(clk), .reset(reset), .set(set),
    .curMin0(cm0), .curMin1(cm1), .curHour0(ch0), .curHour1(ch1),
    .alarm(alarm0)
  );

  alarm_clock_alarm #(.RING_CYCLES(3), .DIGIT_W(4)) dut3 (
    .clk(clk), .reset(reset), .set(set),
    .curMin0(cm0), .curMin1(cm1), .curHour0(ch0), .curHour1(ch1),
    .alarm(alarm3)
  );

  function automatic bit legal_time(int h1, int h0, int m1, int m0);
    return (h1 <= 2) && (h0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 <= 5) && (m0 <= 9);
  endfunction

  task automatic drive(input int h1, input int h0, input int m1, input int m0,
                       input bit s, input bit r);
    ch1 = 4'(h1); ch0 = 4'(h0); cm1 = 4'(m1); cm0 = 4'(m0);
    set = s; reset = r;
  endtask

  // Predict the alarm for the coming edge, clock it, then compare.
  task automatic tick(input string tag);
    bit mt;
    bit acc;
    mt = 1'b0;
    if (reset) begin
      m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0;
      m_armed = 1'b0;
    end else if (set) begin
`ifdef ALARM_TIME_CHECK_EN
      acc = legal_time(int'(ch1), int'(ch0), int'(cm1), int'(cm0));
`else
      acc = 1'b1;
`endif
      if (acc) begin
        m_h1 = ch1; m_h0 = ch0; m_m1 = cm1; m_m0 = cm0;
        m_armed = 1'b1;
      end
    end else begin
      mt = m_armed && ch1 == m_h1 && ch0 == m_h0 && cm1 == m_m1 && cm0 == m_m0;
    end
    m_run = mt ? m_run + 1 : 0;
    e0 = mt;
    e3 = mt && (m_run <= 3);
    @(posedge clk);
    #1;
    step++;
    checks++;
    assert (alarm0 === e0) else begin
      failures++;
      $error("FAIL %s_ring0 step %0d: alarm got %b expected %b", tag, step, alarm0, e0);
    end
    checks++;
    assert (alarm3 === e3) else begin
      failures++;
      $error("FAIL %s_ring3 step %0d: alarm got %b expected %b", tag, step, alarm3, e3);
    end
  endtask

  initial begin
    int hold;
    int h1, h0, m1, m0;
    bit s, r;
    m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0;
    m_armed = 1'b0; m_run = 0;

    // 1: reset, then unarmed at 00:00
    drive(0, 0, 0, 0, 1'b0, 1'b1);
    repeat (5) tick("reset");
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) tick("unarmed");

    // 2: set 09:25, step minutes 20..26
    drive(0, 9, 2, 5, 1'b1, 1'b0);
    repeat (2) tick("set0925");
    for (int i = 0; i <= 6; i++) begin
      drive(0, 9, 2, i, 1'b0, 1'b0);
      tick("step");
    end

    // 3: hold the match for 10 cycles
    drive(0, 9, 2, 5, 1'b0, 1'b0);
    repeat (10) tick("hold");
    drive(0, 9, 2, 6, 1'b0, 1'b0);
    repeat (2) tick("release");

    // 4: set during ring, re-arm at 10:00, old time dead
    drive(0, 9, 2, 5, 1'b0, 1'b0);
    repeat (2) tick("ring");
    drive(0, 9, 2, 5, 1'b1, 1'b0);
    tick("set_mid_ring");
    drive(1, 0, 0, 0, 1'b1, 1'b0);
    tick("set1000");
    drive(0, 9, 2, 5, 1'b0, 1'b0);
    repeat (3) tick("old_time");
    drive(1, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) tick("new_time");

    // 5: reset mid-ring disarms
    drive(0, 9, 5, 9, 1'b0, 1'b0);
    tick("pre");
    drive(1, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) tick("ring1000");
    drive(1, 0, 0, 0, 1'b0, 1'b1);
    tick("reset_mid_ring");
    drive(1, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) tick("disarmed");

    // 6: valid set then an illegal set sample
    drive(0, 7, 3, 0, 1'b1, 1'b0);
    tick("set0730");
    drive(2, 5, 6, 1, 1'b1, 1'b0);
    tick("set2561");
    drive(2, 5, 6, 1, 1'b0, 1'b0);
    repeat (3) tick("at2561");
    drive(0, 7, 2, 9, 1'b0, 1'b0);
    tick("at0729");
    drive(0, 7, 3, 0, 1'b0, 1'b0);
    repeat (5) tick("at0730");

    // boundary: legal 23:59 versus illegal 24:00
    drive(2, 3, 5, 9, 1'b1, 1'b0);
    tick("set2359");
    drive(2, 4, 0, 0, 1'b1, 1'b0);
    tick("set2400");
    drive(2, 3, 5, 9, 1'b0, 1'b0);
    repeat (2) tick("at2359");
    drive(2, 4, 0, 0, 1'b0, 1'b0);
    repeat (2) tick("at2400");

    // randomized phase
    hold = 0;
    h1 = 0; h0 = 0; m1 = 0; m0 = 0;
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 7);
        if ($urandom_range(0, 1) == 0) begin
          h1 = m_h1; h0 = m_h0; m1 = m_m1; m0 = m_m0;
        end else if ($urandom_range(0, 3) == 0) begin
          h1 = $urandom_range(0, 15); h0 = $urandom_range(0, 15);
          m1 = $urandom_range(0, 15); m0 = $urandom_range(0, 15);
        end else begin
          h1 = $urandom_range(0, 2); h0 = $urandom_range(0, 9);
          m1 = $urandom_range(0, 5); m0 = $urandom_range(0, 9);
        end
      end
      hold--;
      s = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 59) == 0);
      drive(h1, h0, m1, m0, s, r);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
